// File: rtl/life_keypad.sv
// Four-channel push-button conditioner: synchronize, debounce and auto-repeat.
// Each key output drops once per accepted press and once per repeat step.
module life_keypad_chan #(
   parameter int unsigned      DB_W            = 16,
   parameter logic [DB_W-1:0]  DEBOUNCE_CYCLES = 16'd50000,
   parameter int unsigned      RPT_W           = 24,
   parameter logic [RPT_W-1:0] REPEAT_DELAY    = 24'd5000000,
   parameter logic [RPT_W-1:0] REPEAT_PERIOD   = 24'd2000000,
   parameter logic             REPEAT_EN       = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic key
);
   localparam logic [2:0] IDLE       = 3'd0;
   localparam logic [2:0] PRESS_DB   = 3'd1;
   localparam logic [2:0] HELD       = 3'd2;
   localparam logic [2:0] GAP        = 3'd3;
   localparam logic [2:0] RPT        = 3'd4;
   localparam logic [2:0] RELEASE_DB = 3'd5;

   localparam logic [DB_W-1:0]  DB_LAST     = DEBOUNCE_CYCLES - 1'b1;
   localparam logic [DB_W-1:0]  GAP_LAST    = DB_W'(1);
   localparam logic [RPT_W-1:0] DELAY_LAST  = REPEAT_DELAY - 1'b1;
   localparam logic [RPT_W-1:0] PERIOD_LAST = REPEAT_PERIOD - 1'b1;

   logic [1:0]       sync;
   logic             s;
   logic [2:0]       state, state_n;
   logic [DB_W-1:0]  dbc, dbc_n;
   logic [RPT_W-1:0] rpt, rpt_n;
   logic             key_n;

   assign s = sync[1];

   // Counters are cleared on every state entry so they only ever count up to a limit.
   always_comb begin
      state_n = state;
      dbc_n   = dbc;
      rpt_n   = rpt;
      case (state)
         IDLE: begin
            dbc_n = '0;
            rpt_n = '0;
            if (s) state_n = PRESS_DB;
         end
         PRESS_DB: begin
            if (!s) begin
               state_n = IDLE;
               dbc_n   = '0;
            end else if (dbc == DB_LAST) begin
               state_n = HELD;
               rpt_n   = '0;
            end else dbc_n = dbc + 1'b1;
         end
         HELD: begin
            if (!s) begin
               state_n = RELEASE_DB;
               dbc_n   = '0;
            end else if (REPEAT_EN) begin
               if (rpt == DELAY_LAST) begin
                  state_n = GAP;
                  dbc_n   = '0;
               end else rpt_n = rpt + 1'b1;
            end
         end
         GAP: begin
            // Two low cycles produce the extra step; dbc times the gap.
            if (dbc == GAP_LAST) begin
               dbc_n   = '0;
               rpt_n   = '0;
               state_n = s ? RPT : IDLE;
            end else dbc_n = dbc + 1'b1;
         end
         RPT: begin
            if (!s) begin
               state_n = RELEASE_DB;
               dbc_n   = '0;
            end else if (rpt == PERIOD_LAST) begin
               state_n = GAP;
               dbc_n   = '0;
            end else rpt_n = rpt + 1'b1;
         end
         RELEASE_DB: begin
            if (s) begin
               state_n = HELD;
               dbc_n   = '0;
               rpt_n   = '0;
            end else if (dbc == DB_LAST) begin
               state_n = IDLE;
               dbc_n   = '0;
            end else dbc_n = dbc + 1'b1;
         end
         default: begin
            state_n = IDLE;
            dbc_n   = '0;
            rpt_n   = '0;
         end
      endcase
      key_n = (state_n == HELD) || (state_n == RPT) || (state_n == RELEASE_DB);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= '0;
         state <= IDLE;
         dbc   <= '0;
         rpt   <= '0;
         key   <= 1'b0;
      end else begin
         sync  <= {sync[0], btn};
         state <= state_n;
         dbc   <= dbc_n;
         rpt   <= rpt_n;
         key   <= key_n;
      end
   end
endmodule

module life_keypad #(
   parameter int unsigned      DB_W            = 16,
   parameter logic [DB_W-1:0]  DEBOUNCE_CYCLES = 16'd50000,
   parameter int unsigned      RPT_W           = 24,
   parameter logic [RPT_W-1:0] REPEAT_DELAY    = 24'd5000000,
   parameter logic [RPT_W-1:0] REPEAT_PERIOD   = 24'd2000000,
   parameter logic             REPEAT_EN       = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_down,
   input  logic btn_up,
   input  logic btn_left,
   input  logic btn_right,
   output logic key_down,
   output logic key_up,
   output logic key_left,
   output logic key_right
);
   logic [3:0] btn_vec;
   logic [3:0] key_vec;

   assign btn_vec = {btn_right, btn_left, btn_up, btn_down};

   for (genvar i = 0; i < 4; i++) begin : g_chan
      life_keypad_chan #(
         .DB_W(DB_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RPT_W(RPT_W),
         .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(REPEAT_EN)
      ) u_chan (
         .clk(clk), .rst_n(rst_n), .btn(btn_vec[i]), .key(key_vec[i])
      );
   end

   assign key_down  = key_vec[0];
   assign key_up    = key_vec[1];
   assign key_left  = key_vec[2];
   assign key_right = key_vec[3];
endmodule

// File: tb/tb_life_keypad.sv
// Bench for life_keypad: directed scenarios plus random button traffic against a
// run-length based reference model, on a repeating and a non-repeating instance.
module tb_life_keypad;
   localparam int DB = 4;
   localparam int RD = 20;
   localparam int RP = 8;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] btn   = '0;
   logic       kd_a, ku_a, kl_a, kr_a, kd_b, ku_b, kl_b, kr_b;
   logic [3:0] ka, kb;
   int         checks = 0;
   int         failures = 0;

   // model: index 0 = repeating instance, 1 = non-repeating instance
   bit s0[2][4], s1[2][4], pv[2][4], on[2][4];
   int run[2][4], since[2][4], lim[2][4], gap[2][4];
   int falls_a[4], falls_b[4];
   logic [3:0] last_a = '0, last_b = '0;
   int hold[4];

   assign ka = {kr_a, kl_a, ku_a, kd_a};
   assign kb = {kr_b, kl_b, ku_b, kd_b};

   always #5 clk = ~clk;

   life_keypad #(.DEBOUNCE_CYCLES(16'd4), .REPEAT_DELAY(24'd20), .REPEAT_PERIOD(24'd8),
                 .REPEAT_EN(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .btn_down(btn[0]), .btn_up(btn[1]), .btn_left(btn[2]),
      .btn_right(btn[3]), .key_down(kd_a), .key_up(ku_a), .key_left(kl_a), .key_right(kr_a));

   life_keypad #(.DEBOUNCE_CYCLES(16'd4), .REPEAT_DELAY(24'd20), .REPEAT_PERIOD(24'd8),
                 .REPEAT_EN(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .btn_down(btn[0]), .btn_up(btn[1]), .btn_left(btn[2]),
      .btn_right(btn[3]), .key_down(kd_b), .key_up(ku_b), .key_left(kl_b), .key_right(kr_b));

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++)
         for (int c = 0; c < 4; c++) begin
            s0[m][c] = 0; s1[m][c] = 0; pv[m][c] = 0; on[m][c] = 0;
            run[m][c] = 0; since[m][c] = 0; lim[m][c] = RD; gap[m][c] = 0;
         end
   endtask

   // A press is accepted after DB+1 consecutive high samples (one to leave idle,
   // DB to debounce); a release after DB+1 consecutive low samples.
   task automatic model_edge(input int m, input int c, input bit raw, input bit ren);
      bit s;
      s = s1[m][c];
      s1[m][c] = s0[m][c];
      s0[m][c] = raw;
      run[m][c] = (s == pv[m][c]) ? run[m][c] + 1 : 1;
      pv[m][c] = s;
      if (gap[m][c] > 0) begin
         gap[m][c]--;
         if (gap[m][c] == 0 && s) begin on[m][c] = 1; since[m][c] = 0; lim[m][c] = RP; end
      end else if (!on[m][c]) begin
         if (s && run[m][c] == DB + 1) begin on[m][c] = 1; since[m][c] = 0; lim[m][c] = RD; end
      end else if (!s) begin
         if (run[m][c] == DB + 1) on[m][c] = 0;
      end else if (run[m][c] == 1) begin
         since[m][c] = 0; lim[m][c] = RD;
      end else if (ren) begin
         if (since[m][c] + 1 == lim[m][c]) begin on[m][c] = 0; gap[m][c] = 2; end
         else since[m][c]++;
      end
   endtask

   function automatic logic [3:0] model_keys(input int m);
      logic [3:0] e;
      for (int c = 0; c < 4; c++) e[c] = on[m][c];
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      if (!rst_n) model_reset();
      else
         for (int c = 0; c < 4; c++) begin
            model_edge(0, c, btn[c], 1'b1);
            model_edge(1, c, btn[c], 1'b0);
         end
      #1;
      chk("keys_rep", ka, model_keys(0));
      chk("keys_norep", kb, model_keys(1));
      for (int c = 0; c < 4; c++) begin
         if (last_a[c] && !ka[c]) falls_a[c]++;
         if (last_b[c] && !kb[c]) falls_b[c]++;
      end
      last_a = ka;
      last_b = kb;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic clear_falls();
      for (int c = 0; c < 4; c++) begin falls_a[c] = 0; falls_b[c] = 0; end
   endtask

   initial begin
      model_reset();
      #12;
      chk("reset_a", ka, 4'b0000);
      chk("reset_b", kb, 4'b0000);
      #10 rst_n = 1'b1;
      ticks(3);

      // clean press on down
      clear_falls();
      btn[0] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (k == 5) chk("press_before", {3'b0, kd_a}, 4'b0000);
         if (k == 6) chk("press_rise", {3'b0, kd_a}, 4'b0001);
      end
      btn[0] = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (k == 5) chk("release_before", {3'b0, kd_a}, 4'b0001);
         if (k == 6) chk("release_fall", {3'b0, kd_a}, 4'b0000);
      end
      chk_int("press_falls", falls_a[0], 1);
      chk_int("press_others", falls_a[1] + falls_a[2] + falls_a[3], 0);

      // glitch on up, then a release bounce while held
      clear_falls();
      btn[1] = 1'b1;
      ticks(3);
      btn[1] = 1'b0;
      ticks(10);
      chk_int("glitch_falls", falls_a[1], 0);
      btn[1] = 1'b1;
      ticks(8);
      chk("bounce_held", {3'b0, ku_a}, 4'b0001);
      btn[1] = 1'b0;
      ticks(2);
      btn[1] = 1'b1;
      ticks(8);
      chk_int("bounce_falls", falls_a[1], 0);
      btn[1] = 1'b0;
      ticks(10);
      chk_int("bounce_release", falls_a[1], 1);

      // auto-repeat on left
      clear_falls();
      btn[2] = 1'b1;
      for (int k = 0; k < 60; k++) begin
         logic e;
         tick();
         e = (k >= 6) && !(k >= 26 && ((k - 26) % 10) < 2);
         chk("repeat_level", {3'b0, kl_a}, {3'b0, e});
         chk("norepeat_level", {3'b0, kl_b}, {3'b0, (k >= 6)});
      end
      btn[2] = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (k == 5) chk("repeat_rel_before", {3'b0, kl_a}, 4'b0001);
         if (k == 6) chk("repeat_rel_fall", {3'b0, kl_a}, 4'b0000);
      end
      chk_int("repeat_falls", falls_a[2], 5);
      chk_int("norepeat_falls", falls_b[2], 1);

      // simultaneous right + down
      clear_falls();
      btn[0] = 1'b1;
      btn[3] = 1'b1;
      for (int k = 0; k < 60; k++) begin
         tick();
         if (k == 5) chk("simul_before", ka & 4'b1001, 4'b0000);
         if (k == 6) chk("simul_rise", ka & 4'b1001, 4'b1001);
      end
      btn = '0;
      ticks(10);
      chk_int("simul_rep_falls", falls_a[0] + falls_a[3], 10);
      chk_int("simul_norep_falls", falls_b[0] + falls_b[3], 2);

      // asynchronous reset while in repeat
      btn[2] = 1'b1;
      ticks(30);
      chk("pre_reset_rpt", {3'b0, kl_a}, 4'b0001);
      #3 rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_reset_a", ka, 4'b0000);
      chk("async_reset_b", kb, 4'b0000);
      ticks(2);
      #3 rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (k == 5) chk("post_reset_before", {3'b0, kl_a}, 4'b0000);
         if (k == 6) chk("post_reset_rise", {3'b0, kl_a}, 4'b0001);
      end
      btn = '0;
      ticks(12);

      // random traffic: mostly short bursts, sometimes holds long enough to repeat
      for (int c = 0; c < 4; c++) hold[c] = $urandom_range(1, 8);
      repeat (800) begin
         for (int c = 0; c < 4; c++) begin
            if (hold[c] == 0) begin
               btn[c] = ~btn[c];
               hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 70) : $urandom_range(1, 8);
            end else hold[c]--;
         end
         tick();
      end
      btn = '0;
      ticks(30);
      chk("final_idle", ka | kb, 4'b0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/life_keypad.md
LIFE_KEYPAD -- requirements
Module: life_keypad

Interface
REQ-001 The block SHALL have parameter DB_W, default 16, giving the debounce counter width in bits.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 16'd50000, giving the number of consecutive stable synchronized cycles needed to accept a press or a release (legal range 1..2^DB_W-1).
REQ-003 The block SHALL have parameter RPT_W, default 24, giving the repeat counter width in bits.
REQ-004 The block SHALL have parameter REPEAT_DELAY, default 24'd5000000, giving the number of cycles held before the first auto-repeat (legal range >=1).
REQ-005 The block SHALL have parameter REPEAT_PERIOD, default 24'd2000000, giving the number of high cycles between subsequent auto-repeats (legal range >=1).
REQ-006 The block SHALL have parameter REPEAT_EN, default 1'b1, where 0 disables auto-repeat.
REQ-007 Port clk SHALL be an input, 1 bit: the single clock; all logic is on the rising edge.
REQ-008 Port rst_n SHALL be an input, 1 bit: reset, asynchronous and active-low.
REQ-009 Ports btn_down, btn_up, btn_left, btn_right SHALL each be an input, 1 bit: raw asynchronous push-buttons, active-high.
REQ-010 Ports key_down, key_up, key_left, key_right SHALL each be an output reg, 1 bit: cleaned key levels for the cursor block, where each high-to-low transition counts as one step.

Function
REQ-011 The four channels SHALL be identical and fully independent; simultaneous buttons SHALL produce simultaneous, unarbitrated outputs.
REQ-012 Each raw button SHALL pass through a 2-flop synchronizer; "s" below denotes the synchronized value.
REQ-013 Each channel SHALL have FSM states IDLE, PRESS_DB, HELD, GAP, RPT and RELEASE_DB, a DB_W-bit debounce counter and an RPT_W-bit repeat counter.
REQ-014 In IDLE the key output SHALL be 0; s=1 SHALL move the channel to PRESS_DB with the debounce counter cleared.
REQ-015 In PRESS_DB:
- s=0 SHALL return the channel to IDLE (glitch rejected, no output change).
- Debounce counter == DEBOUNCE_CYCLES-1 with s=1 SHALL move the channel to HELD, set the key output to 1 and clear the repeat counter.
- Otherwise the debounce counter SHALL increment.
REQ-016 Press latency: if edge 0 first samples raw high and the input stays stable, the key output SHALL be 1 after edge DEBOUNCE_CYCLES+2.
REQ-017 In HELD the key output SHALL be 1, with these transitions:
- s=0 SHALL move the channel to RELEASE_DB with the debounce counter cleared.
- Otherwise, if REPEAT_EN=1 and the repeat counter == REPEAT_DELAY-1, the channel SHALL move to GAP.
- Otherwise the repeat counter SHALL increment.
- If REPEAT_EN=0, the channel SHALL never leave HELD except via s=0.
REQ-018 In GAP the key output SHALL be 0 for exactly 2 cycles, producing one extra step. After the 2nd cycle the channel SHALL go to RPT (output 1, repeat counter cleared) if s=1, else to IDLE.
REQ-019 In RPT the key output SHALL be 1, with these transitions:
- s=0 SHALL move the channel to RELEASE_DB.
- Repeat counter == REPEAT_PERIOD-1 SHALL move the channel to GAP.
- Otherwise the repeat counter SHALL increment.
REQ-020 In RELEASE_DB:
- The key output SHALL stay 1.
- s=1 SHALL return the channel to HELD with both counters cleared (bounce rejected, repeat delay restarts).
- DEBOUNCE_CYCLES consecutive s=0 cycles SHALL move the channel to IDLE and drive the key output to 0 (the release step).
REQ-021 Release latency: with raw low stable from edge 0, the key output SHALL fall after edge DEBOUNCE_CYCLES+2.
REQ-022 The block SHALL emit exactly one falling edge per accepted press plus one per auto-repeat, and no falling edge SHALL occur without a prior debounced press.
REQ-023 Counters SHALL never wrap: each is cleared on every state entry and compared for equality against parameter-1.
REQ-024 Illegal or unused FSM encodings SHALL recover to IDLE on the next clock with the key output at 0.

Reset
REQ-025 While rst_n=0, all channels SHALL be asynchronously forced to IDLE with synchronizer flops, counters and key_* at 0, regardless of clk.
REQ-026 Reset asserted mid-press or mid-repeat SHALL drop the key output to 0 immediately. After release of reset, a held button SHALL require a full PRESS_DB interval before the output is reasserted.
REQ-027 Deassertion of rst_n SHALL take effect on the following clk rising edge; no output change SHALL occur on the deasserting edge itself.

Verification
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
REQ-028 Clean press: btn_down high for 10 cycles, then low -> key_down rises after edge 6, falls 6 edges after the release; exactly one falling edge; other outputs stay 0.
REQ-029 Glitch: btn_up pulses high for 3 cycles -> key_up stays 0; a release bounce of 2 low cycles while held -> no key_up falling edge.
REQ-030 Auto-repeat: btn_left held 60 cycles -> key_left high at edge 6, first 2-cycle low gap 20 cycles later, then a gap every 10 cycles (8 high + 2 low), then a final fall after release debounce.
REQ-031 Simultaneous: btn_right and btn_down rise on the same edge -> both outputs rise on the same edge 6; REPEAT_EN=0 with a 60-cycle hold -> no gaps.
REQ-032 Reset mid-operation: rst_n=0 asynchronously during RPT -> all key_* at 0 within the same cycle; button still held after reset release -> output reasserts 6 edges after rst_n rises.
